hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 95 +++++++++
 tb/tb_hazard_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data, mult/div and eret stalls with interrupt flush.
// Macro HAZARD_MD_STALL_EN enables the mult/div busy tracker and its stall term.
//
// state   | meaning
// MD_IDLE | mult/div unit free
// MD_RUN  | mult/div in progress, counter holds remaining busy cycles
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_ID,
  input  logic [4:0] rt_ID,
  input  logic [1:0] tuse_rs,
  input  logic [1:0] tuse_rt,
  input  logic [4:0] dst_EX,
  input  logic [4:0] dst_MEM,
  input  logic [1:0] tnew_EX,
  input  logic [1:0] tnew_MEM,
  input  logic       md_use_ID,
  input  logic       md_start_EX,
  input  logic       md_div_EX,
  input  logic       eret_ID,
  input  logic       mtc0_epc_EX,
  input  logic       mtc0_epc_MEM,
  input  logic       IntReq,
  output logic       en_PC,
  output logic       en_IF_ID,
  output logic       flush_ID_EX,
  output logic       flush_all,
  output logic       stall,
  output logic       md_busy
);

  logic stall_rs, stall_rt, stall_data, stall_md, stall_eret, stall_any;

  // Register 0 never carries a dependency; tuse of 3 can never be below a 2-bit tnew.
  assign stall_rs = (rs_ID != 5'd0) &&
                    (((rs_ID == dst_EX)  && (tuse_rs < tnew_EX)) ||
                     ((rs_ID == dst_MEM) && (tuse_rs < tnew_MEM)));
  assign stall_rt = (rt_ID != 5'd0) &&
                    (((rt_ID == dst_EX)  && (tuse_rt < tnew_EX)) ||
                     ((rt_ID == dst_MEM) && (tuse_rt < tnew_MEM)));
  assign stall_data = stall_rs | stall_rt;
  assign stall_eret = eret_ID & (mtc0_epc_EX | mtc0_epc_MEM);

`ifdef HAZARD_MD_STALL_EN
  localparam logic MD_IDLE = 1'b0;
  localparam logic MD_RUN  = 1'b1;

  logic       md_state;
  logic [3:0] md_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      md_state <= MD_IDLE;
      md_cnt   <= 4'd0;
    end else begin
      case (md_state)
        MD_IDLE: begin
          if (md_start_EX) begin
            md_state <= MD_RUN;
            md_cnt   <= md_div_EX ? 4'd10 : 4'd5;
          end
        end
        MD_RUN: begin
          // A new start while running is ignored; the count is never reloaded.
          md_cnt <= md_cnt - 4'd1;
          if (md_cnt == 4'd1) md_state <= MD_IDLE;
        end
        default: begin
          md_state <= MD_IDLE;
          md_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign md_busy  = (md_state == MD_RUN);
  assign stall_md = md_use_ID & (md_busy | md_start_EX);
`else
  logic unused_md;
  assign unused_md = ^{clk, md_use_ID, md_start_EX, md_div_EX};
  assign md_busy   = 1'b0;
  assign stall_md  = 1'b0;
`endif

  assign stall_any = stall_data | stall_md | stall_eret;

  // Reset forces the free-running enables; IntReq overrides every stall.
  assign stall       = ~reset & ~IntReq & stall_any;
  assign flush_all   = ~reset & IntReq;
  assign en_PC       = ~stall;
  assign en_IF_ID    = ~stall;
  assign flush_ID_EX = stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed cases then random vectors vs a rule-level model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_ID, rt_ID, dst_EX, dst_MEM;
  logic [1:0] tuse_rs, tuse_rt, tnew_EX, tnew_MEM;
  logic       md_use_ID, md_start_EX, md_div_EX, eret_ID;
  logic       mtc0_epc_EX, mtc0_epc_MEM, IntReq;
  logic       en_PC, en_IF_ID, flush_ID_EX, flush_all, stall, md_busy;

  int vectors = 0;
  int miscompares = 0;
  int busy_left = 0;  // model: remaining mult/div busy cycles

`ifdef HAZARD_MD_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .rs_ID(rs_ID), .rt_ID(rt_ID),
    .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .dst_EX(dst_EX), .dst_MEM(dst_MEM),
    .tnew_EX(tnew_EX), .tnew_MEM(tnew_MEM), .md_use_ID(md_use_ID),
    .md_start_EX(md_start_EX), .md_div_EX(md_div_EX), .eret_ID(eret_ID),
    .mtc0_epc_EX(mtc0_epc_EX), .mtc0_epc_MEM(mtc0_epc_MEM), .IntReq(IntReq),
    .en_PC(en_PC), .en_IF_ID(en_IF_ID), .flush_ID_EX(flush_ID_EX),
    .flush_all(flush_all), .stall(stall), .md_busy(md_busy)
  );

  function automatic bit src_hazard(input logic [4:0] r, input logic [1:0] t);
    bit h = 1'b0;
    if (r != 0) begin
      if (r == dst_EX  && int'(t) < int'(tnew_EX))  h = 1'b1;
      if (r == dst_MEM && int'(t) < int'(tnew_MEM)) h = 1'b1;
    end
    return h;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic clear_inputs();
    rs_ID = 0; rt_ID = 0; dst_EX = 0; dst_MEM = 0;
    tuse_rs = 3; tuse_rt = 3; tnew_EX = 0; tnew_MEM = 0;
    md_use_ID = 0; md_start_EX = 0; md_div_EX = 0; eret_ID = 0;
    mtc0_epc_EX = 0; mtc0_epc_MEM = 0; IntReq = 0;
  endtask

  // Inputs must already be driven; checks mid-cycle, then advances one clock.
  task automatic step(input string tag);
    bit busy, want_stall, e_stall, e_fall;
    #3;
    busy = MD_EN && (busy_left > 0);
    want_stall = src_hazard(rs_ID, tuse_rs) || src_hazard(rt_ID, tuse_rt) ||
                 (MD_EN && md_use_ID && (busy || md_start_EX)) ||
                 (eret_ID && (mtc0_epc_EX || mtc0_epc_MEM));
    e_stall = !reset && !IntReq && want_stall;
    e_fall  = !reset && IntReq;
    chk({tag, ".stall"},       stall,       e_stall);
    chk({tag, ".en_PC"},       en_PC,       !e_stall);
    chk({tag, ".en_IF_ID"},    en_IF_ID,    !e_stall);
    chk({tag, ".flush_ID_EX"}, flush_ID_EX, e_stall);
    chk({tag, ".flush_all"},   flush_all,   e_fall);
    chk({tag, ".md_busy"},     md_busy,     busy);
    @(posedge clk);
    if (reset) busy_left = 0;
    else if (busy_left > 0) busy_left--;
    else if (MD_EN && md_start_EX) busy_left = md_div_EX ? 10 : 5;
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    step("reset_hold");
    reset = 0;
    step("idle");

    rs_ID = 5; tuse_rs = 0; dst_EX = 5; tnew_EX = 1;
    step("data_ex");
    chk("data_ex.const_stall", stall, 1'b1);
    rs_ID = 0; dst_EX = 0; tnew_EX = 2;
    step("r0_nohaz");
    chk("r0_nohaz.const_enpc", en_PC, 1'b1);
    clear_inputs(); rt_ID = 7; tuse_rt = 1; dst_MEM = 7; tnew_MEM = 2;
    step("data_mem_rt");
    tuse_rt = 2;
    step("tuse_eq_tnew");
    clear_inputs(); rs_ID = 5; tuse_rs = 0; dst_EX = 5; tnew_EX = 1; IntReq = 1;
    step("int_override");
    chk("int_override.const_flush", flush_all, 1'b1);
    clear_inputs(); eret_ID = 1; mtc0_epc_MEM = 1;
    step("eret_mem");
    mtc0_epc_MEM = 0;
    step("eret_clear");
    chk("eret_clear.const_stall", stall, 1'b0);
    reset = 1; rs_ID = 5; tuse_rs = 0; dst_EX = 5; tnew_EX = 1; eret_ID = 1; mtc0_epc_EX = 1;
    step("reset_mask");
    reset = 0; clear_inputs();

    if (MD_EN) begin
      md_use_ID = 1; md_start_EX = 1; md_div_EX = 1;
      step("div_start");
      md_start_EX = 0; md_div_EX = 0;
      for (int i = 0; i < 10; i++) begin
        chk("div_busy_const", md_busy, 1'b1);
        step("div_run");
      end
      chk("div_done_const", md_busy, 1'b0);
      step("div_done");
      md_use_ID = 0; md_start_EX = 1;
      step("mult_start");
      md_start_EX = 0;
      step("mult_run1");
      reset = 1; md_use_ID = 1;
      step("mult_reset");
      reset = 0;
      chk("after_reset_busy_const", md_busy, 1'b0);
      step("after_reset");
      md_use_ID = 0;
    end

    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 39) == 0);
      rs_ID        = 5'($urandom_range(0, 3));
      rt_ID        = 5'($urandom_range(0, 3));
      dst_EX       = 5'($urandom_range(0, 3));
      dst_MEM      = 5'($urandom_range(0, 3));
      tuse_rs      = 2'($urandom_range(0, 3));
      tuse_rt      = 2'($urandom_range(0, 3));
      tnew_EX      = 2'($urandom_range(0, 3));
      tnew_MEM     = 2'($urandom_range(0, 3));
      md_use_ID    = $urandom_range(0, 1);
      md_start_EX  = ($urandom_range(0, 5) == 0);
      md_div_EX    = $urandom_range(0, 1);
      eret_ID      = ($urandom_range(0, 3) == 0);
      mtc0_epc_EX  = ($urandom_range(0, 2) == 0);
      mtc0_epc_MEM = ($urandom_range(0, 2) == 0);
      IntReq       = ($urandom_range(0, 9) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
